// File: rtl/pc_stack_unit.sv
// Program counter with a circular return-address stack.
// Supports INC/JUMP/BRANCH/CALL/RET with sticky overflow and underflow flags.
module pc_stack_unit #(
    parameter int                 WIDTH     = 32,
    parameter int                 STEP      = 4,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         contro,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             datain,
    output logic [WIDTH-1:0]             dataout,
    output logic [WIDTH-1:0]             link_out,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [CW-1:0]    FULL   = CW'(RAS_DEPTH);

    localparam logic [2:0] M_INC    = 3'b000;
    localparam logic [2:0] M_JUMP   = 3'b001;
    localparam logic [2:0] M_BRANCH = 3'b010;
    localparam logic [2:0] M_CALL   = 3'b011;
    localparam logic [2:0] M_RET    = 3'b100;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    sp_q, sp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             push;
    logic [WIDTH-1:0] seq_pc;
    logic [PW-1:0]    top_idx;

    assign seq_pc  = pc_q + STEP_W;
    // sp points at the next free slot; the top entry sits one below it
    assign top_idx = sp_q - PW'(1);

    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (contro) begin
            case (mode)
                M_JUMP:   pc_d = datain;
                M_BRANCH: pc_d = pc_q + datain;
                M_CALL: begin
                    push = 1'b1;
                    pc_d = datain;
                    sp_d = sp_q + PW'(1);
                    if (cnt_q == FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                M_RET: begin
                    if (cnt_q == '0) begin
                        pc_d  = seq_pc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d  = ras_q[top_idx];
                        sp_d  = top_idx;
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default:  pc_d = seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage is never cleared; link_out masks it while empty
    always_ff @(posedge clk) begin
        if (reset && push) begin
            ras_q[sp_q] <= seq_pc;
        end
    end

    assign dataout   = pc_q;
    assign link_out  = (cnt_q == '0) ? RESET_VEC : ras_q[top_idx];
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC and data width in bits.
REQ-002 Parameter STEP, default 4: sequential increment added to the PC.
REQ-003 Parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two and at least 2.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-007 Port contro, input, 1: update enable; 1 = apply mode this edge; 0 = hold all state (stall).
REQ-008 Port mode, input, 3: 000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET; 101-111 treated as INC.
REQ-009 Port datain, input, WIDTH: jump target, branch offset (two's complement) or call target.
REQ-010 Port dataout, output, WIDTH: current PC, registered.
REQ-011 Port link_out, output, WIDTH: top-of-stack entry; RESET_VEC when the stack is empty.
REQ-012 Port ras_count, output, clog2(RAS_DEPTH)+1: number of valid stack entries.
REQ-013 Port ras_ovf, output, 1: sticky overflow flag.
REQ-014 Port ras_unf, output, 1: sticky underflow flag.

Function
REQ-015 All outputs SHALL be registered or derived only from registered state; no combinational path from inputs to outputs.
REQ-016 New PC SHALL appear on dataout one clk edge after the edge sampling contro=1.
REQ-017 INC: PC <= PC + STEP.
REQ-018 JUMP: PC <= datain.
REQ-019 BRANCH: PC <= PC + datain.
REQ-020 CALL: push PC + STEP; PC <= datain.
REQ-021 RET: pop the top entry; PC <= popped value.
REQ-022 All PC arithmetic SHALL be modulo 2^WIDTH, so 0xFFFFFFFC + 4 = 0 at WIDTH=32.
REQ-023 contro=0 SHALL leave the PC, stack, count and flags unchanged regardless of mode and datain.
REQ-024 CALL with a full stack SHALL:
- overwrite the oldest entry (circular);
- keep ras_count at RAS_DEPTH;
- set ras_ovf;
- still perform the jump.
REQ-025 RET with an empty stack SHALL:
- set PC <= PC + STEP;
- set ras_unf;
- leave ras_count at 0.
REQ-026 Stack pointer wrap SHALL be modulo RAS_DEPTH.
- Pops after an overflow return the most recent RAS_DEPTH addresses in LIFO order.
REQ-027 ras_ovf and ras_unf SHALL remain set until reset.

Reset
REQ-028 reset=0 SHALL immediately, independent of clk, force:
- dataout = RESET_VEC;
- ras_count = 0, stack pointer = 0;
- ras_ovf = 0, ras_unf = 0;
- link_out = RESET_VEC.
REQ-029 While reset=0, clock edges SHALL have no effect.
REQ-030 After reset deassertion, the first update SHALL occur on the first rising edge with contro=1.
REQ-031 Stack entry contents need not be cleared on reset; they SHALL NOT be observable while ras_count=0.

Verification (WIDTH=32, STEP=4, RESET_VEC=0, RAS_DEPTH=4)
REQ-032 Reset/stall scenario:
- reset=0 -> dataout=0, ras_count=0, flags=0.
- Release reset with contro=0, mode=INC, for 3 cycles -> dataout stays 0.
REQ-033 Sequential/jump/branch scenario, contro=1:
- INC x3 -> dataout 4, 8, 12.
- JUMP datain=0x100 -> 0x100.
- BRANCH datain=0xFFFFFFF8 -> 0xF8.
REQ-034 Call/return scenario:
- PC=0x10, CALL datain=0x200 -> dataout=0x200, link_out=0x14, ras_count=1.
- RET -> dataout=0x14, ras_count=0, link_out=0.
REQ-035 Overflow/underflow scenario:
- Five CALLs from PCs 0x0, 0x100, 0x200, 0x300, 0x400 -> ras_count=4, ras_ovf=1.
- Four RETs -> 0x404, 0x304, 0x204, 0x104.
- Fifth RET -> PC=0x108, ras_unf=1.
REQ-036 Wrap/async-reset/stall scenario:
- JUMP 0xFFFFFFFC then INC -> dataout=0.
- Assert reset between edges -> dataout=0 and flags=0 before the next edge.
- contro=0 with mode=CALL -> PC and stack unchanged.
